alu_result_stage: RTL



---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_result_stage.sv | 113 +++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode indices, widths and result-stage state encoding
package alu_pkg;

    localparam int ALU_OP_W = 16;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_NEG = 2;
    localparam int OP_MUL = 3;
    localparam int OP_DIV = 4;
    localparam int OP_AND = 5;
    localparam int OP_OR  = 6;
    localparam int OP_ROR = 7;
    localparam int OP_ROL = 8;
    localparam int OP_SLL = 9;
    localparam int OP_SRA = 10;
    localparam int OP_SRL = 11;
    localparam int OP_NOT = 12;
    localparam int OP_INC = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU op sequencer and ZHI/ZLO capture; ALU_ONEHOT_CHECK_EN adds err output
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int OP_W       = ALU_OP_W,
    parameter int DIV_CYCLES = 34,
    parameter int DIV_IDX    = OP_DIV
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [63:0]     alu_z,
    output logic [OP_W-1:0] alu_op,
    output logic            busy,
    output logic            done,
`ifdef ALU_ONEHOT_CHECK_EN
    output logic            err,
`endif
    output logic [31:0]     zhi,
    output logic [31:0]     zlo
);

    localparam int              CNT_W    = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       zhi_q, zhi_d;
    logic [31:0]       zlo_q, zlo_d;
    logic              accept;
`ifdef ALU_ONEHOT_CHECK_EN
    logic              err_q, err_d;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            zhi_q   <= '0;
            zlo_q   <= '0;
`ifdef ALU_ONEHOT_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
`ifdef ALU_ONEHOT_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Malformed opcodes are rejected only when the check is compiled in
    always_comb begin
`ifdef ALU_ONEHOT_CHECK_EN
        accept = start && $onehot(op);
        err_d  = (state_q == IDLE) && start && !$onehot(op);
`else
        accept = start;
`endif
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        zhi_d   = zhi_q;
        zlo_d   = zlo_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = op;
                    cnt_d   = op[DIV_IDX] ? DIV_LOAD : '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    zhi_d   = alu_z[63:32];
                    zlo_d   = alu_z[31:0];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Opcode is driven only in EXEC so the divider sits in reset otherwise
    always_comb begin
        alu_op = (state_q == EXEC) ? op_q : '0;
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        zhi    = zhi_q;
        zlo    = zlo_q;
`ifdef ALU_ONEHOT_CHECK_EN
        err    = err_q;
`endif
    end

endmodule
